// File: rtl/wb_pkg.sv
// Shared definitions for the write-back queue.
// Contents: default data/select widths, default queue depth, and the {reg, data} entry type.
package wb_pkg;

  localparam int unsigned DW            = 16;
  localparam int unsigned AW            = 3;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // One pending register-file write.
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-match search for one register-file read port.
// Slots are supplied oldest first. Slot 0 is the output register, followed by the queue from
// head to tail. The last valid slot whose register matches sel wins, so the youngest match wins.
// Ports:
//   sel    read selector to look up
//   valid  per-slot valid mask
//   regs   per-slot destination registers, packed with slot 0 in the LSBs
//   datas  per-slot data, packed with slot 0 in the LSBs
//   hit    some valid slot targets sel
//   data   data of the youngest matching slot (0 when there is no hit)
module wb_match
  import wb_pkg::*;
#(
  parameter int unsigned N  = DEFAULT_DEPTH + 1,
  parameter int unsigned DW = wb_pkg::DW,
  parameter int unsigned AW = wb_pkg::AW
) (
  input  logic [AW-1:0]   sel,
  input  logic [N-1:0]    valid,
  input  logic [N*AW-1:0] regs,
  input  logic [N*DW-1:0] datas,
  output logic            hit,
  output logic [DW-1:0]   data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (regs[i*AW +: AW] == sel)) begin
        hit  = 1'b1;
        data = datas[i*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue that owns the register file's single write port.
// ALU and load results are buffered in arrival order. The ALU result is older when both
// producers push in the same cycle. One entry retires per cycle through a registered
// write/writeregsel/writedata port. Pending writes to either read selector are flagged as
// hazards.
// Optional feature macro: WB_BYPASS_EN forwards the youngest pending data for each read port.
// When the macro is undefined, the forward outputs are held at 0.
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   alu_valid/ready/reg/data ALU producer handshake
//   ld_valid/ready/reg/data  load producer handshake
//   write/writeregsel/writedata  registered register-file write port
//   read1regsel/read2regsel  register-file read selectors
//   hazard1/hazard2          a pending write targets the matching read selector
//   fwd1_valid/fwd1data, fwd2_valid/fwd2data  forwarded pending data
//   count                    number of occupied entries
//   err                      sticky flag, set if occupancy is ever seen above DEPTH
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned DW    = wb_pkg::DW,
  parameter int unsigned AW    = wb_pkg::AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_reg,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_reg,
  input  logic [DW-1:0]            ld_data,
  output logic                     write,
  output logic [AW-1:0]            writeregsel,
  output logic [DW-1:0]            writedata,
  input  logic [AW-1:0]            read1regsel,
  input  logic [AW-1:0]            read2regsel,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic                     fwd1_valid,
  output logic                     fwd2_valid,
  output logic [DW-1:0]            fwd1data,
  output logic [DW-1:0]            fwd2data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned N  = DEPTH + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] LD_MAX = CW'(DEPTH - 2);

  logic [AW-1:0] mem_reg  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, ld_idx;
  logic [CW-1:0] count_q, count_d;
  logic          err_q;
  logic          write_q;
  logic [AW-1:0] wsel_q;
  logic [DW-1:0] wdata_q;

  logic alu_push, ld_push, pop;

  // Readiness is based only on the registered count. The load side keeps two slots free so
  // that a same-cycle ALU push always fits.
  assign alu_ready = (count_q < FULL);
  assign ld_ready  = (count_q <= LD_MAX);
  assign alu_push  = alu_valid & alu_ready;
  assign ld_push   = ld_valid & ld_ready;
  assign pop       = (count_q != '0);

  // The load entry goes behind the ALU entry when both producers push together.
  assign ld_idx = tail_q + PW'(alu_push);

  always_comb begin
    head_d  = pop ? head_q + PW'(1) : head_q;
    tail_d  = tail_q + PW'(alu_push) + PW'(ld_push);
    count_d = count_q + CW'(alu_push) + CW'(ld_push) - CW'(pop);
  end

  // Storage is not reset. Entries are qualified by count.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      mem_reg[tail_q]  <= alu_reg;
      mem_data[tail_q] <= alu_data;
    end
    if (ld_push) begin
      mem_reg[ld_idx]  <= ld_reg;
      mem_data[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      wsel_q  <= '0;
      wdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_q | (count_q > FULL);
      write_q <= pop;
      // When nothing retires, select and data keep their last values.
      if (pop) begin
        wsel_q  <= mem_reg[head_q];
        wdata_q <= mem_data[head_q];
      end
    end
  end

  assign write       = write_q;
  assign writeregsel = wsel_q;
  assign writedata   = wdata_q;
  assign count       = count_q;
  assign err         = err_q;

  // Build slots oldest first for the match units: the output register, then the queue entries
  // from head to tail.
  logic [N-1:0]    slot_valid;
  logic [N*AW-1:0] slot_reg;
  logic [N*DW-1:0] slot_data;
  logic [PW-1:0]   idx;

  always_comb begin
    slot_valid        = '0;
    slot_reg          = '0;
    slot_data         = '0;
    idx               = '0;
    slot_valid[0]     = write_q;
    slot_reg[0 +: AW] = wsel_q;
    slot_data[0 +: DW] = wdata_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx                         = head_q + PW'(i);
      slot_valid[i+1]             = (CW'(i) < count_q);
      slot_reg[(i+1)*AW +: AW]    = mem_reg[idx];
      slot_data[(i+1)*DW +: DW]   = mem_data[idx];
    end
  end

  logic          m1_hit, m2_hit;
  logic [DW-1:0] m1_data, m2_data;

  wb_match #(.N(N), .DW(DW), .AW(AW)) u_match1 (
    .sel   (read1regsel),
    .valid (slot_valid),
    .regs  (slot_reg),
    .datas (slot_data),
    .hit   (m1_hit),
    .data  (m1_data)
  );

  wb_match #(.N(N), .DW(DW), .AW(AW)) u_match2 (
    .sel   (read2regsel),
    .valid (slot_valid),
    .regs  (slot_reg),
    .datas (slot_data),
    .hit   (m2_hit),
    .data  (m2_data)
  );

  assign hazard1 = m1_hit;
  assign hazard2 = m2_hit;

`ifdef WB_BYPASS_EN
  assign fwd1_valid = m1_hit;
  assign fwd2_valid = m2_hit;
  assign fwd1data   = m1_data;
  assign fwd2data   = m2_data;
`else
  // Without bypass the consumer must stall on a hazard, so the match data goes unused.
  logic unused_fwd;
  assign unused_fwd = ^{m1_data, m2_data};
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1data   = '0;
  assign fwd2data   = '0;
`endif

endmodule
